sec_r_search_12bits: RTL

SEC_R_SEARCH_12BITS -- requirements
Module: sec_r_search_12bits

---
 rtl/sec_an_pkg.sv | 13 +
 rtl/sec_pow2_mod_step.sv | 19 +
 rtl/sec_r_search_12bits.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sec_an_pkg.sv
// Shared constants and FSM state type for the AN-code single-error remainder search.
package sec_an_pkg;
  localparam int A    = 3349;
  localparam int NPOS = 24;
  localparam int R_W  = 12;
  localparam int L_W  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/sec_pow2_mod_step.sv
// One doubling step of a power of two modulo A: p_nx = 2p mod A, for p < A.
module sec_pow2_mod_step #(
  parameter int A   = 3349,
  parameter int R_W = 12
) (
  input  logic [R_W-1:0] p,
  output logic [R_W-1:0] p_nx
);
  localparam int W = R_W + 1;
  localparam logic [W-1:0] A_W = W'(A);

  logic [W-1:0] dbl;
  logic [W-1:0] red;

  // 2p < 2A, so a single conditional subtract is enough.
  assign dbl  = {p, 1'b0};
  assign red  = dbl - A_W;
  assign p_nx = (dbl >= A_W) ? red[R_W-1:0] : dbl[R_W-1:0];
endmodule

// File: rtl/sec_r_search_12bits.sv
// Maps an AN-code remainder r to a signed error location l by walking +/-2^(k-1) mod A.
// Optional macro SEC_EARLY_EXIT_EN: finish as soon as the answer is known.
module sec_r_search_12bits
  import sec_an_pkg::*;
#(
  parameter int A    = sec_an_pkg::A,
  parameter int NPOS = sec_an_pkg::NPOS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [R_W-1:0]   r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [L_W-1:0]   l,
  output logic             err,
  output logic             uncorr
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid on either side.

  localparam logic [R_W-1:0] A_R    = R_W'(A);
  localparam logic [L_W-1:0] NPOS_L = L_W'(NPOS);

  state_t         state, state_nx;
  logic [R_W-1:0] r_q;
  logic [R_W-1:0] p;
  logic [R_W-1:0] p_nx;
  logic [R_W-1:0] p_neg;
  logic [L_W-1:0] k;
  logic [L_W-1:0] l_q;
  logic           err_q;
  logic           uncorr_q;
  logic           found;

  logic accept;
  logic r_in_range;
  logic hit_pos;
  logic hit_neg;
  logic hit;
  logic last_iter;
  logic trivial_in;

  sec_pow2_mod_step #(.A(A), .R_W(R_W)) u_step (
    .p    (p),
    .p_nx (p_nx)
  );

  assign accept     = in_valid & in_ready;
  assign p_neg      = A_R - p;
  assign r_in_range = (r_q != '0) && (r_q < A_R);
  // Only the first match counts; once found, later candidates are ignored.
  assign hit_pos    = r_in_range && !found && (r_q == p);
  assign hit_neg    = r_in_range && !found && !hit_pos && (r_q == p_neg);
  assign hit        = hit_pos | hit_neg;
  assign last_iter  = (k == NPOS_L);
  assign trivial_in = (r == '0) || (r >= A_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SEC_EARLY_EXIT_EN
          state_nx = trivial_in ? DONE : SEARCH;
`else
          state_nx = SEARCH;
`endif
        end
      end
      SEARCH: begin
`ifdef SEC_EARLY_EXIT_EN
        if (hit || last_iter) state_nx = DONE;
`else
        if (last_iter) state_nx = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      p        <= '0;
      k        <= '0;
      l_q      <= '0;
      err_q    <= 1'b0;
      uncorr_q <= 1'b0;
      found    <= 1'b0;
    end else if (accept) begin
      r_q      <= r;
      p        <= R_W'(1);
      k        <= L_W'(1);
      l_q      <= '0;
      err_q    <= (r != '0);
      // Out-of-range remainders can never match; flag them up front so the
      // early-exit path already holds the final answer.
      uncorr_q <= (r >= A_R);
      found    <= 1'b0;
    end else if (state == SEARCH) begin
      p <= p_nx;
      k <= k + 1'b1;
      if (hit) begin
        found <= 1'b1;
        l_q   <= hit_pos ? k : (L_W'(0) - k);
      end
      if (last_iter) uncorr_q <= (r_q != '0) && !(found | hit);
    end
  end

  assign l      = l_q;
  assign err    = err_q;
  assign uncorr = uncorr_q;
endmodule
